// File: rtl/path_stepper.sv
// Streams a captured node path one node per valid/ready handshake, from slot 0 up to end_node.
// Reports done on reaching end_node, or err on a filler slot or on exhausting all slots.
module path_stepper #(
  parameter int NODE_W    = 5,
  parameter int MAX_NODES = 20,
  parameter int NO_NODE   = 31
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [NODE_W-1:0]           end_node_i,
  input  logic [NODE_W*MAX_NODES-1:0] path_in_i,
  output logic [NODE_W-1:0]           node_out_o,
  output logic                        node_valid_o,
  input  logic                        node_ready_i,
  output logic [4:0]                  step_idx_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);

  localparam int PATH_W = NODE_W * MAX_NODES;
  localparam logic [NODE_W-1:0] FILL     = NODE_W'(NO_NODE);
  localparam logic [4:0]        LAST_IDX = 5'(MAX_NODES - 1);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE, S_ERR} state_t;

  state_t              state_q, state_d;
  logic [PATH_W-1:0]   buf_q, buf_d;
  logic [NODE_W-1:0]   end_q, end_d;
  logic [4:0]          idx_q, idx_d;
  logic [NODE_W-1:0]   head;
  logic                head_fill;

  // The buffer shifts down on every transfer, so the current slot is always the low node.
  assign head      = buf_q[NODE_W-1:0];
  assign head_fill = (head == FILL);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      end_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      end_q   <= end_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    end_d   = end_q;
    idx_d   = idx_q;
    case (state_q)
      S_EMIT: begin
        if (head_fill) begin
          state_d = S_ERR;
        end else if (node_ready_i) begin
          if (head == end_q) begin
            state_d = S_DONE;
          end else if (idx_q == LAST_IDX) begin
            state_d = S_ERR;
          end else begin
            buf_d = {FILL, buf_q[PATH_W-1:NODE_W]};
            idx_d = idx_q + 5'd1;
          end
        end
      end
      default: begin
        if (start_i) begin
          buf_d   = path_in_i;
          end_d   = end_node_i;
          idx_d   = '0;
          state_d = S_EMIT;
        end
      end
    endcase
  end

  always_comb begin
    node_out_o   = '0;
    node_valid_o = 1'b0;
    step_idx_o   = '0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    err_o        = 1'b0;
    case (state_q)
      S_EMIT: begin
        busy_o       = 1'b1;
        node_out_o   = head;
        node_valid_o = !head_fill;
        step_idx_o   = idx_q;
      end
      S_DONE: begin
        done_o     = 1'b1;
        step_idx_o = idx_q;
      end
      S_ERR: begin
        err_o      = 1'b1;
        step_idx_o = idx_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_path_stepper.sv
// Scoreboard bench for path_stepper: stimulus queues expected {idx,node} pairs,
// a monitor pops and compares on every handshake seen at the falling edge.
module tb_path_stepper;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [4:0]   end_node = '0;
  logic [99:0]  path = '1;
  logic [4:0]   node_out;
  logic         node_valid;
  logic         node_ready = 1'b1;
  logic [4:0]   step_idx;
  logic         busy, done, err;

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  path_stepper dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .end_node_i(end_node),
    .path_in_i(path), .node_out_o(node_out), .node_valid_o(node_valid),
    .node_ready_i(node_ready), .step_idx_o(step_idx), .busy_o(busy),
    .done_o(done), .err_o(err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every handshake must match the head of the expected queue.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (!rst && node_valid && node_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_xfer: got node %0d idx %0d, expected none", node_out, step_idx);
        end else begin
          e = exp_q.pop_front();
          if ({step_idx, node_out} != e) begin
            errors++;
            $display("FAIL xfer: got node %0d idx %0d, expected node %0d idx %0d",
                     node_out, step_idx, e[4:0], e[9:5]);
          end
        end
      end
    end
  end

  task automatic fill_path();
    path = '1;
  endtask

  task automatic set_slot(input int k, input logic [4:0] v);
    path[5*k +: 5] = v;
  endtask

  task automatic push_exp(input int idx, input int node);
    exp_q.push_back({5'(idx), 5'(node)});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Counts falling edges after the start pulse until done or err, bounded.
  task automatic wait_end(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(done || err) && n < 100);
    if (!(done || err)) chk("timeout_end", 0, 1);
  endtask

  task automatic std_path();
    fill_path();
    set_slot(0, 5'd0); set_slot(1, 5'd1); set_slot(2, 5'd2); set_slot(3, 5'd25);
    end_node = 5'd25;
  endtask

  initial begin
    int n;

    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", node_valid, 0);
    chk("rst_node", node_out, 0);
    chk("rst_idx", step_idx, 0);
    chk("rst_done_err", {done, err}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: basic stream with full throughput
    std_path();
    node_ready = 1'b1;
    push_exp(0, 0); push_exp(1, 1); push_exp(2, 2); push_exp(3, 25);
    pulse_start();
    wait_end(n);
    chk("t1_cycles", n, 5);
    chk("t1_done", done, 1);
    chk("t1_err", err, 0);
    chk("t1_busy", busy, 0);
    chk("t1_valid", node_valid, 0);
    chk("t1_idx", step_idx, 3);
    chk("t1_q_empty", exp_q.size(), 0);

    // 2: backpressure while node 1 is presented
    std_path();
    push_exp(0, 0); push_exp(1, 1); push_exp(2, 2); push_exp(3, 25);
    pulse_start();
    @(posedge clk); #1 node_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t2_hold_node", node_out, 1);
      chk("t2_hold_idx", step_idx, 1);
      chk("t2_hold_valid", node_valid, 1);
    end
    @(posedge clk); #1 node_ready = 1'b1;
    wait_end(n);
    chk("t2_done", done, 1);
    chk("t2_idx", step_idx, 3);
    chk("t2_q_empty", exp_q.size(), 0);

    // 3: twenty valid slots without end_node
    for (int k = 0; k < 20; k++) begin
      set_slot(k, 5'(k));
      push_exp(k, k);
    end
    end_node = 5'd25;
    pulse_start();
    wait_end(n);
    chk("t3_cycles", n, 21);
    chk("t3_err", err, 1);
    chk("t3_done", done, 0);
    chk("t3_busy", busy, 0);
    chk("t3_q_empty", exp_q.size(), 0);

    // 4: filler slot before end_node
    fill_path();
    set_slot(0, 5'd0); set_slot(1, 5'd5);
    end_node = 5'd25;
    push_exp(0, 0); push_exp(1, 5);
    pulse_start();
    wait_end(n);
    chk("t4_cycles", n, 4);
    chk("t4_err", err, 1);
    chk("t4_done", done, 0);
    chk("t4_q_empty", exp_q.size(), 0);

    // 5: start during EMIT is ignored
    std_path();
    push_exp(0, 0); push_exp(1, 1); push_exp(2, 2); push_exp(3, 25);
    pulse_start();
    @(posedge clk); #1;
    path = {20{5'd7}};
    end_node = 5'd7;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_end(n);
    chk("t5_done", done, 1);
    chk("t5_err", err, 0);
    chk("t5_idx", step_idx, 3);
    chk("t5_q_empty", exp_q.size(), 0);

    // 6: asynchronous reset mid-stream
    fill_path();
    for (int k = 0; k < 20; k++) begin
      set_slot(k, 5'(k));
      push_exp(k, k);
    end
    end_node = 5'd25;
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_valid", node_valid, 0);
    chk("t6_node", node_out, 0);
    chk("t6_idx", step_idx, 0);
    chk("t6_done_err", {done, err}, 0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_valid", node_valid, 0);
    chk("t6_idle_done_err", {done, err}, 0);

    // 7: start node equals end_node
    fill_path();
    set_slot(0, 5'd25);
    end_node = 5'd25;
    push_exp(0, 25);
    pulse_start();
    wait_end(n);
    chk("t7_cycles", n, 2);
    chk("t7_done", done, 1);
    chk("t7_idx", step_idx, 0);
    chk("t7_q_empty", exp_q.size(), 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
